alu_exec_unit: RTL

- Execute-stage ALU that consumes the 3-bit ALU operation code produced by the ALU control decoder and returns a registered result to the EX/MEM boundary.
- Single-cycle ops: ADD/SUB/AND/OR/SLT. SLL runs as an iterative shifter, one bit per cycle.
- Valid/ready handshake on both sides, so the pipeline stalls while a shift is in progress.

---
 rtl/alu_exec_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT, iterative one-bit-per-cycle SLL,
// valid/ready on both sides. Define ALU_OVF_EN to add the registered signed-overflow output ovf.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] alu_res;
  logic             accept;
  logic             start_shift;

  assign sum         = op_a + op_b;
  assign diff        = op_a - op_b;
  assign acc_sh      = {acc[WIDTH-2:0], 1'b0};
  assign accept      = in_valid && in_ready;
  assign start_shift = (alu_op == OP_SLL) && (shamt != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  alu_res = op_a;  // only reaches result when shamt == 0
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic alu_ovf;

  // Signed overflow: the result sign disagrees with what the operand signs allow.
  always_comb begin
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD:  alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      OP_SUB:  alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
`ifdef ALU_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef ALU_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (start_shift) begin
              acc   <= op_a;
              cnt   <= shamt;
              state <= S_SHIFT;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
`ifdef ALU_OVF_EN
              ovf       <= alu_ovf;
`endif
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_SHIFT: begin
          // The edge that takes the counter to zero also commits the final shifted value.
          if (cnt == '0) begin
            result    <= acc;
            zero      <= (acc == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
          end else if (cnt == SHW'(1)) begin
            cnt       <= '0;
            result    <= acc_sh;
            zero      <= (acc_sh == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
          end else begin
            acc <= acc_sh;
            cnt <= cnt - SHW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
